// File: rtl/lock_sequencer.sv
// lock_sequencer
//   Central sequencing FSM for the combination-lock datapath. Converts
//   synchronised button presses into single-cycle command pulses for the
//   code checker, programs and collects the code digit by digit, issues the
//   compare, evaluates the checker's answer, counts failed attempts and
//   enforces a timed lockout.
//
// Ports
//   clk                 system clock (CLOCK_50)
//   resetn              asynchronous active-low reset
//   store_btn           store request (active-high, synchronised)
//   input_btn           digit-entry request (active-high)
//   submit_btn          submit / relock request (active-high)
//   correct_password    checker result: match
//   incorrect_password  checker result: mismatch
//   store_value         pulse: latch digit into the system register
//   input_value         pulse: latch digit into the input register
//   compare             pulse: start compare
//   input_reset         pulse: clear the input register
//   system_reset        pulse: clear the system register
//   digit_sel[1:0]      digit index used by the current store/input pulse
//   unlocked            high in OPEN
//   locked_out          high in LOCKOUT
//   attempts_left[1:0]  remaining attempts
//   state_dbg[2:0]      current state encoding
//
// Optional feature
//   LOCK_SEQ_AUTO_RELOCK_EN: when defined, OPEN relocks itself after
//   RELOCK_CYCLES cycles with an input_reset pulse. When undefined, OPEN
//   persists until a submit or store event and no relock timer exists.

module lock_sequencer #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 150000000,
  parameter int unsigned RESULT_TIMEOUT = 8,
  parameter int unsigned RELOCK_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       store_btn,
  input  logic       input_btn,
  input  logic       submit_btn,
  input  logic       correct_password,
  input  logic       incorrect_password,
  output logic       store_value,
  output logic       input_value,
  output logic       compare,
  output logic       input_reset,
  output logic       system_reset,
  output logic [1:0] digit_sel,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] attempts_left,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_UNSET   = 3'd0,
    ST_LOCKED  = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int unsigned LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned RT_W = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;

  localparam logic [LK_W-1:0] LK_LOAD   = LK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [RT_W-1:0] RT_LOAD   = RT_W'(RESULT_TIMEOUT - 1);
  localparam logic [2:0]      IDX_FULL  = 3'(DIGITS);
  localparam logic [1:0]      ATT_MAX   = 2'(MAX_ATTEMPTS);

  if (DIGITS < 1 || DIGITS > 4 || MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 3 ||
      LOCKOUT_CYCLES < 1 || RESULT_TIMEOUT < 1 || RELOCK_CYCLES < 1) begin : g_param_check
    $error("lock_sequencer: parameter out of range");
  end

`ifdef LOCK_SEQ_AUTO_RELOCK_EN
  localparam int unsigned RL_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
  localparam logic [RL_W-1:0] RL_LOAD = RL_W'(RELOCK_CYCLES - 1);
  logic [RL_W-1:0] relock_q, relock_d;
`endif

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      att_q, att_d;
  logic [RT_W-1:0] res_tmr_q, res_tmr_d;
  logic [LK_W-1:0] lk_tmr_q, lk_tmr_d;
  logic            store_prev_q, input_prev_q, submit_prev_q;
  logic            store_value_q, store_value_d;
  logic            input_value_q, input_value_d;
  logic            compare_q, compare_d;
  logic            input_reset_q, input_reset_d;
  logic            system_reset_q, system_reset_d;
  logic            unlocked_q, unlocked_d;
  logic            locked_out_q, locked_out_d;

  logic sub_ev, inp_ev, sto_ev;

  // Rising edges, arbitrated submit > input > store; losers are dropped.
  always_comb begin
    sub_ev = submit_btn & ~submit_prev_q;
    inp_ev = input_btn  & ~input_prev_q & ~sub_ev;
    sto_ev = store_btn  & ~store_prev_q & ~sub_ev & ~inp_ev;
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    sel_d          = sel_q;
    att_d          = att_q;
    res_tmr_d      = res_tmr_q;
    lk_tmr_d       = lk_tmr_q;
    store_value_d  = 1'b0;
    input_value_d  = 1'b0;
    compare_d      = 1'b0;
    input_reset_d  = 1'b0;
    system_reset_d = 1'b0;
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
    relock_d       = relock_q;
`endif

    unique case (state_q)
      ST_UNSET: begin
        if (idx_q == IDX_FULL) begin
          idx_d   = '0;
          state_d = ST_LOCKED;
        end else if (sto_ev) begin
          store_value_d = 1'b1;
          sel_d         = idx_q[1:0];
          idx_d         = idx_q + 3'd1;
        end
      end

      ST_LOCKED: begin
        if (sub_ev) begin
          if (idx_q == IDX_FULL) begin
            compare_d = 1'b1;
            res_tmr_d = RT_LOAD;
            state_d   = ST_CHECK;
          end else begin
            input_reset_d = 1'b1;
            idx_d         = '0;
          end
        end else if (inp_ev && idx_q != IDX_FULL) begin
          input_value_d = 1'b1;
          sel_d         = idx_q[1:0];
          idx_d         = idx_q + 3'd1;
        end
      end

      ST_CHECK: begin
        if (correct_password) begin
          state_d = ST_OPEN;
          att_d   = ATT_MAX;
          idx_d   = '0;
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
          relock_d = RL_LOAD;
`endif
        end else if (incorrect_password || res_tmr_q == '0) begin
          input_reset_d = 1'b1;
          att_d         = att_q - 2'd1;
          idx_d         = '0;
          if (att_q == 2'd1) begin
            state_d  = ST_LOCKOUT;
            lk_tmr_d = LK_LOAD;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          res_tmr_d = res_tmr_q - 1'b1;
        end
      end

      ST_OPEN: begin
        if (sub_ev) begin
          input_reset_d = 1'b1;
          idx_d         = '0;
          state_d       = ST_LOCKED;
        end else if (sto_ev) begin
          system_reset_d = 1'b1;
          input_reset_d  = 1'b1;
          idx_d          = '0;
          state_d        = ST_UNSET;
        end
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
        else if (relock_q == '0) begin
          input_reset_d = 1'b1;
          idx_d         = '0;
          state_d       = ST_LOCKED;
        end else begin
          relock_d = relock_q - 1'b1;
        end
`endif
      end

      ST_LOCKOUT: begin
        if (lk_tmr_q == '0) begin
          att_d   = ATT_MAX;
          state_d = ST_LOCKED;
        end else begin
          lk_tmr_d = lk_tmr_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_UNSET;
        idx_d   = '0;
      end
    endcase

    // Flags follow the next state so they are registered alongside it.
    unlocked_d   = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_UNSET;
      idx_q          <= '0;
      sel_q          <= '0;
      att_q          <= ATT_MAX;
      res_tmr_q      <= '0;
      lk_tmr_q       <= '0;
      // History starts high so a button held through reset does not fire.
      store_prev_q   <= 1'b1;
      input_prev_q   <= 1'b1;
      submit_prev_q  <= 1'b1;
      store_value_q  <= 1'b0;
      input_value_q  <= 1'b0;
      compare_q      <= 1'b0;
      input_reset_q  <= 1'b0;
      system_reset_q <= 1'b0;
      unlocked_q     <= 1'b0;
      locked_out_q   <= 1'b0;
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
      relock_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      sel_q          <= sel_d;
      att_q          <= att_d;
      res_tmr_q      <= res_tmr_d;
      lk_tmr_q       <= lk_tmr_d;
      store_prev_q   <= store_btn;
      input_prev_q   <= input_btn;
      submit_prev_q  <= submit_btn;
      store_value_q  <= store_value_d;
      input_value_q  <= input_value_d;
      compare_q      <= compare_d;
      input_reset_q  <= input_reset_d;
      system_reset_q <= system_reset_d;
      unlocked_q     <= unlocked_d;
      locked_out_q   <= locked_out_d;
`ifdef LOCK_SEQ_AUTO_RELOCK_EN
      relock_q       <= relock_d;
`endif
    end
  end

  assign store_value   = store_value_q;
  assign input_value   = input_value_q;
  assign compare       = compare_q;
  assign input_reset   = input_reset_q;
  assign system_reset  = system_reset_q;
  assign digit_sel     = sel_q;
  assign unlocked      = unlocked_q;
  assign locked_out    = locked_out_q;
  assign attempts_left = att_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;

  logic       clk;
  logic       resetn;
  logic       store_btn, input_btn, submit_btn;
  logic       correct_password, incorrect_password;
  logic       store_value, input_value, compare, input_reset, system_reset;
  logic [1:0] digit_sel;
  logic       unlocked, locked_out;
  logic [1:0] attempts_left;
  logic [2:0] state_dbg;

  int passed = 0;
  int total  = 0;

  // Pulse counters and the digit_sel seen with each store/input pulse.
  int n_store = 0, n_input = 0, n_cmp = 0, n_ireset = 0, n_sreset = 0;
  logic [1:0] sel_log[$];

  lock_sequencer #(
    .DIGITS        (4),
    .MAX_ATTEMPTS  (3),
    .LOCKOUT_CYCLES(20),
    .RESULT_TIMEOUT(8),
    .RELOCK_CYCLES (1000)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .store_btn         (store_btn),
    .input_btn         (input_btn),
    .submit_btn        (submit_btn),
    .correct_password  (correct_password),
    .incorrect_password(incorrect_password),
    .store_value       (store_value),
    .input_value       (input_value),
    .compare           (compare),
    .input_reset       (input_reset),
    .system_reset      (system_reset),
    .digit_sel         (digit_sel),
    .unlocked          (unlocked),
    .locked_out        (locked_out),
    .attempts_left     (attempts_left),
    .state_dbg         (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (store_value) begin n_store++; sel_log.push_back(digit_sel); end
    if (input_value) begin n_input++; sel_log.push_back(digit_sel); end
    if (compare)      n_cmp++;
    if (input_reset)  n_ireset++;
    if (system_reset) n_sreset++;
  end

  // Steps land 1 ns after a falling edge, after the monitor has sampled.
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic press(input int which);
    case (which)
      0: store_btn  = 1'b1;
      1: input_btn  = 1'b1;
      default: submit_btn = 1'b1;
    endcase
    step(2);
    store_btn = 1'b0; input_btn = 1'b0; submit_btn = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    store_btn = 1'b0; input_btn = 1'b0; submit_btn = 1'b0;
    correct_password = 1'b0; incorrect_password = 1'b0;
    step(2);
    total++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else passed++;
    total++; if (attempts_left !== 2'd3) $display("FAIL reset_attempts: got %0d expected 3", attempts_left); else passed++;
    total++;
    if ({store_value, input_value, compare, input_reset, system_reset, unlocked, locked_out} !== 7'b0)
      $display("FAIL reset_outputs: got %b expected 0000000",
               {store_value, input_value, compare, input_reset, system_reset, unlocked, locked_out});
    else passed++;
    total++; if (digit_sel !== 2'd0) $display("FAIL reset_digit_sel: got %0d expected 0", digit_sel); else passed++;
    resetn = 1'b1;
    step(2);
  endtask

  task automatic test_program();
    sel_log.delete();
    for (int i = 0; i < 4; i++) press(0);
    step(1);
    total++; if (n_store !== 4) $display("FAIL prog_count: got %0d expected 4", n_store); else passed++;
    total++; if (sel_log.size() !== 4) $display("FAIL prog_sel_size: got %0d expected 4", sel_log.size()); else passed++;
    for (int i = 0; i < 4 && i < sel_log.size(); i++) begin
      total++;
      if (sel_log[i] !== 2'(i)) $display("FAIL prog_sel%0d: got %0d expected %0d", i, sel_log[i], i);
      else passed++;
    end
    total++; if (state_dbg !== 3'd1) $display("FAIL prog_state: got %0d expected 1", state_dbg); else passed++;
    total++; if (n_input !== 0) $display("FAIL prog_no_input: got %0d expected 0", n_input); else passed++;
  endtask

  task automatic test_correct_entry();
    sel_log.delete();
    for (int i = 0; i < 4; i++) press(1);
    total++; if (n_input !== 4) $display("FAIL entry_count: got %0d expected 4", n_input); else passed++;
    for (int i = 0; i < 4 && i < sel_log.size(); i++) begin
      total++;
      if (sel_log[i] !== 2'(i)) $display("FAIL entry_sel%0d: got %0d expected %0d", i, sel_log[i], i);
      else passed++;
    end
    submit_btn = 1'b1;
    step(1);
    total++; if (compare !== 1'b1) $display("FAIL cmp_pulse: got %b expected 1", compare); else passed++;
    total++; if (state_dbg !== 3'd2) $display("FAIL cmp_state: got %0d expected 2", state_dbg); else passed++;
    submit_btn = 1'b0;
    step(1);
    total++; if (compare !== 1'b0) $display("FAIL cmp_width: got %b expected 0", compare); else passed++;
    correct_password = 1'b1;
    step(1);
    correct_password = 1'b0;
    total++; if (unlocked !== 1'b1) $display("FAIL open_unlocked: got %b expected 1", unlocked); else passed++;
    total++; if (state_dbg !== 3'd3) $display("FAIL open_state: got %0d expected 3", state_dbg); else passed++;
    total++; if (attempts_left !== 2'd3) $display("FAIL open_attempts: got %0d expected 3", attempts_left); else passed++;
    total++; if (n_cmp !== 1) $display("FAIL cmp_count: got %0d expected 1", n_cmp); else passed++;
    begin
      int r0;
      r0 = n_ireset;
      press(2);
      total++; if (n_ireset !== r0 + 1) $display("FAIL relock_ireset: got %0d expected %0d", n_ireset, r0 + 1); else passed++;
      total++; if (state_dbg !== 3'd1) $display("FAIL relock_state: got %0d expected 1", state_dbg); else passed++;
      total++; if (unlocked !== 1'b0) $display("FAIL relock_unlocked: got %b expected 0", unlocked); else passed++;
    end
  endtask

  task automatic test_lockout();
    int s0, i0, c0, r0, y0;
    for (int a = 0; a < 3; a++) begin
      for (int i = 0; i < 4; i++) press(1);
      press(2);
      incorrect_password = 1'b1;
      step(1);
      incorrect_password = 1'b0;
      total++; if (input_reset !== 1'b1) $display("FAIL wrong%0d_ireset: got %b expected 1", a, input_reset); else passed++;
      total++;
      if (attempts_left !== 2'(2 - a)) $display("FAIL wrong%0d_attempts: got %0d expected %0d", a, attempts_left, 2 - a);
      else passed++;
    end
    total++; if (locked_out !== 1'b1) $display("FAIL lockout_flag: got %b expected 1", locked_out); else passed++;
    total++; if (state_dbg !== 3'd4) $display("FAIL lockout_state: got %0d expected 4", state_dbg); else passed++;
    s0 = n_store; i0 = n_input; c0 = n_cmp; r0 = n_ireset; y0 = n_sreset;
    press(1); press(2); press(0);
    step(10);
    total++; if (state_dbg !== 3'd4) $display("FAIL lockout_hold19: got %0d expected 4", state_dbg); else passed++;
    total++;
    if (n_store !== s0 || n_input !== i0 || n_cmp !== c0 || n_ireset !== r0 || n_sreset !== y0)
      $display("FAIL lockout_no_pulses: got %0d expected 0", (n_store - s0) + (n_input - i0) + (n_cmp - c0) + (n_ireset - r0) + (n_sreset - y0));
    else passed++;
    step(1);
    total++; if (state_dbg !== 3'd1) $display("FAIL lockout_exit_state: got %0d expected 1", state_dbg); else passed++;
    total++; if (attempts_left !== 2'd3) $display("FAIL lockout_exit_attempts: got %0d expected 3", attempts_left); else passed++;
    total++; if (locked_out !== 1'b0) $display("FAIL lockout_exit_flag: got %b expected 0", locked_out); else passed++;
  endtask

  task automatic test_back_to_back();
    int i0, r0;
    press(1); press(1);
    i0 = n_input; r0 = n_ireset;
    submit_btn = 1'b1; input_btn = 1'b1;
    step(2);
    submit_btn = 1'b0; input_btn = 1'b0;
    step(1);
    total++; if (n_input !== i0) $display("FAIL simul_no_input: got %0d expected %0d", n_input, i0); else passed++;
    total++; if (n_ireset !== r0 + 1) $display("FAIL simul_ireset: got %0d expected %0d", n_ireset, r0 + 1); else passed++;
    total++; if (attempts_left !== 2'd3) $display("FAIL simul_attempts: got %0d expected 3", attempts_left); else passed++;
    total++; if (state_dbg !== 3'd1) $display("FAIL simul_state: got %0d expected 1", state_dbg); else passed++;
    sel_log.delete();
    press(1);
    total++;
    if (sel_log.size() !== 1 || sel_log[0] !== 2'd0) $display("FAIL simul_index_cleared: got %0d expected 0", digit_sel);
    else passed++;
    press(1); press(1); press(1);
  endtask

  task automatic test_timeout();
    int i0, k;
    i0 = n_input;
    press(1);
    total++; if (n_input !== i0) $display("FAIL full_input_ignored: got %0d expected %0d", n_input, i0); else passed++;
    submit_btn = 1'b1;
    step(1);
    submit_btn = 1'b0;
    total++; if (compare !== 1'b1) $display("FAIL to_cmp: got %b expected 1", compare); else passed++;
    k = 0;
    do begin step(1); k++; end while (input_reset !== 1'b1 && k < 20);
    total++; if (k !== 8) $display("FAIL to_latency: got %0d expected 8", k); else passed++;
    total++; if (attempts_left !== 2'd2) $display("FAIL to_attempts: got %0d expected 2", attempts_left); else passed++;
    total++; if (state_dbg !== 3'd1) $display("FAIL to_state: got %0d expected 1", state_dbg); else passed++;
  endtask

  task automatic test_reset_mid();
    int s0;
    for (int i = 0; i < 4; i++) press(1);
    press(2);
    total++; if (state_dbg !== 3'd2) $display("FAIL mid_pre_state: got %0d expected 2", state_dbg); else passed++;
    resetn = 1'b0;
    store_btn = 1'b1;
    #1;
    total++; if (state_dbg !== 3'd0) $display("FAIL mid_state: got %0d expected 0", state_dbg); else passed++;
    total++; if (attempts_left !== 2'd3) $display("FAIL mid_attempts: got %0d expected 3", attempts_left); else passed++;
    total++;
    if ({store_value, input_value, compare, input_reset, system_reset, unlocked, locked_out} !== 7'b0)
      $display("FAIL mid_outputs: got %b expected 0000000",
               {store_value, input_value, compare, input_reset, system_reset, unlocked, locked_out});
    else passed++;
    step(2);
    s0 = n_store;
    resetn = 1'b1;
    step(3);
    total++; if (n_store !== s0) $display("FAIL held_store_no_pulse: got %0d expected %0d", n_store, s0); else passed++;
    store_btn = 1'b0;
    step(1);
    sel_log.delete();
    press(0);
    total++; if (n_store !== s0 + 1) $display("FAIL repress_store: got %0d expected %0d", n_store, s0 + 1); else passed++;
    total++;
    if (sel_log.size() !== 1 || sel_log[0] !== 2'd0) $display("FAIL repress_sel: got %0d expected 0", digit_sel);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_program();
    test_correct_entry();
    test_lockout();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Central sequencing FSM for the combination-lock datapath. Turns button presses into single-cycle command pulses for the code checker.
- Programs the stored code digit by digit, collects the entered code, issues compare and evaluates the result.
- Counts failed attempts and enforces a timed lockout.
- Sits between the button inputs and the code checker; its unlock and lockout flags drive LEDR.

Parameters:
- DIGITS, 4, code length in digits (1..4).
- MAX_ATTEMPTS, 3, failed compares allowed before lockout (1..3).
- LOCKOUT_CYCLES, 150000000, lockout duration in clk cycles (3 s at 50 MHz).
- RESULT_TIMEOUT, 8, cycles to wait for a checker result before treating the attempt as a failure.
- RELOCK_CYCLES, 500000000, open-state auto-relock time; used only with the optional feature.

Ports:
- clk  input  1  system clock (CLOCK_50)
- resetn  input  1  asynchronous, active-low reset
- store_btn  input  1  store request, active-high, already synchronised
- input_btn  input  1  digit-entry request, active-high
- submit_btn  input  1  submit/relock request, active-high
- correct_password  input  1  checker result: match
- incorrect_password  input  1  checker result: mismatch
- store_value  output  1  one-cycle pulse: checker latches digit into the system register
- input_value  output  1  one-cycle pulse: checker latches digit into the input register
- compare  output  1  one-cycle pulse: start compare
- input_reset  output  1  one-cycle pulse: clear the input register
- system_reset  output  1  one-cycle pulse: clear the system register
- digit_sel  output  2  index of the digit being stored or entered
- unlocked  output  1  high in OPEN
- locked_out  output  1  high in LOCKOUT
- attempts_left  output  2  remaining attempts
- state_dbg  output  3  current state encoding

Behaviour:
- Reset (resetn low, asynchronous): state UNSET, digit index 0, attempts_left=MAX_ATTEMPTS, timers 0.
  - All pulse outputs 0; unlocked=0; locked_out=0.
  - Button history registers reset to 1, so a button held through reset does not fire.
- Edge detection: an event is btn & ~btn_prev. Every output is registered, so a command pulse is high for exactly the one cycle after the edge is sampled.
- Priority when several events occur in the same cycle: submit > input > store. Lower-priority events that cycle are discarded.
- digit_sel equals the index used by the current pulse, held stable around it.
- UNSET (state_dbg 0):
  - store event: store_value pulse; index++.
  - When index reaches DIGITS: index=0, go to LOCKED.
  - input and submit events are ignored.
- LOCKED (1):
  - input event while index<DIGITS: input_value pulse; index++. An input event at index==DIGITS is ignored.
  - submit event with index==DIGITS: compare pulse; go to CHECK; start the result timer.
  - submit event with index<DIGITS: input_reset pulse; index=0; no attempt consumed.
  - store event is ignored.
- CHECK (2):
  - correct_password high: go to OPEN; attempts_left=MAX_ATTEMPTS; index=0.
  - Otherwise, incorrect_password high, or RESULT_TIMEOUT cycles elapsed: input_reset pulse; attempts_left--; index=0.
    - If attempts_left becomes 0: go to LOCKOUT; load the lockout timer.
    - Else: go to LOCKED.
  - If both result inputs are high in the same cycle, correct wins.
  - Buttons are ignored.
- OPEN (3): unlocked=1.
  - submit event: input_reset pulse; go to LOCKED.
  - store event: system_reset and input_reset pulses together; index=0; go to UNSET (re-program).
  - input event is ignored.
- LOCKOUT (4): locked_out=1; all buttons ignored.
  - Down-counter runs from LOCKOUT_CYCLES-1 to 0.
  - At 0: attempts_left=MAX_ATTEMPTS; go to LOCKED.
- Timer widths use $clog2 of the relevant parameter; no wrap-around occurs, since counters stop at 0.
- Reset asserted mid-operation returns to UNSET immediately; no pulses are emitted during reset.

Optional Feature:
- Macro: LOCK_SEQ_AUTO_RELOCK_EN.
- Defined: an OPEN timer loads RELOCK_CYCLES-1 on entry to OPEN and counts down. At 0 the block issues an input_reset pulse and returns to LOCKED. Any button event in OPEN keeps its normal action.
- Undefined: OPEN persists until a submit or store event; no timer logic is generated.

Test Plan (DIGITS=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=20, RESULT_TIMEOUT=8):
- Program the code: 4 store_btn rises -> 4 store_value pulses with digit_sel 0,1,2,3; state_dbg 0->1 after the 4th pulse.
- Correct entry: 4 input_btn rises, then submit -> input_value pulses 0..3, then compare pulse; drive correct_password 2 cycles later -> unlocked=1, attempts_left=3.
- Three wrong entries, each answered with incorrect_password -> attempts_left 2,1,0; locked_out=1.
  - Inputs pressed during lockout produce no pulses.
  - Exactly 20 cycles later: state LOCKED, attempts_left=3.
- Simultaneous submit+input rise in LOCKED with index 2 -> single input_reset pulse, no input_value pulse, attempts_left unchanged.
- No checker response after compare -> after 8 cycles: input_reset pulse, attempts_left decrements by 1.
- resetn low mid-CHECK, with store_btn held through reset -> outputs cleared at once, state UNSET; no store_value pulse after resetn rises until store_btn is released and pressed again.
